fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter LAT, default 3, SHALL give the fixed datapath latency in cycles from dp_valid to dp_result; legal range 1..8.
REQ-002 Parameter RSP_DEPTH, default 2, SHALL give the per-requester response buffer depth; legal range 1..4.
REQ-003 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_L  in  1  reset, asynchronous assert, active-low.
REQ-005 reqK_valid  in  1  requester K (K=0,1) has an operation pending.
REQ-006 reqK_ready  out  1  requester K operation accepted this cycle when reqK_valid is also 1.
REQ-007 reqK_a, reqK_b  in  16 each  fp16_t operands.
REQ-008 reqK_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 reserved (passed through uninterpreted).
REQ-009 dp_valid  out  1  issue strobe to the shared FP16 datapath.
REQ-010 dp_a, dp_b  out  16 each; dp_op  out  2  registered operands and opcode for the datapath.
REQ-011 dp_result  in  16; dp_flags  in  3  datapath output, {OF,UF,NX}, valid exactly LAT cycles after dp_valid.
REQ-012 rspK_valid  out  1; rspK_ready  in  1  response handshake for requester K.
REQ-013 rspK_result  out  16; rspK_flags  out  3  head of requester K response buffer.
REQ-014 busy  out  1  any operation in flight or any response buffered.

Function
REQ-015 Credit: eligible_K SHALL be 1 iff inflight_K + occupancy_K < RSP_DEPTH; inflight_K counts handshakes not yet written to buffer K.
REQ-016 Arbitration SHALL be round-robin with pointer rr: both valid and eligible -> grant rr; exactly one valid and eligible -> grant it; at most one grant per cycle.
REQ-017 reqK_ready SHALL be combinational, 1 only for the granted requester; never both 1.
REQ-018 After a grant to K, rr SHALL become the other requester; with no grant, rr SHALL hold.
REQ-019 On handshake in cycle t, dp_valid SHALL be 1 in cycle t+1 with dp_a/dp_b/dp_op equal to the accepted values; dp_valid SHALL be 0 in cycles with no issue; back-to-back issue SHALL be supported.
REQ-020 A LAT-deep tag pipeline of {valid, id} SHALL track each issue; when a valid tag emerges (cycle t+1+LAT), {dp_result, dp_flags} SHALL be pushed into buffer id at the end of that cycle.
REQ-021 Earliest rspK_valid SHALL be cycle t+2+LAT; responses per requester SHALL return in issue order.
REQ-022 Each response buffer SHALL be a FIFO; pop on rspK_valid & rspK_ready; rspK_result/flags SHALL be stable while rspK_valid & ~rspK_ready.
REQ-023 Push and pop on the same buffer in the same cycle SHALL leave occupancy unchanged and preserve order, including at occupancy RSP_DEPTH.
REQ-024 Credit accounting SHALL guarantee no push to a full buffer; inflight_K SHALL increment on handshake and decrement on push, and both in one cycle SHALL net zero.
REQ-025 A pop in cycle c SHALL make eligible_K available in cycle c+1, not combinationally in c.
REQ-026 dp_result/dp_flags in cycles with no valid emerging tag SHALL be ignored.
REQ-027 busy SHALL be 1 iff any tag valid, dp_valid, or any buffer non-empty.

Reset
REQ-028 While reset_L=0: dp_valid=0, reqK_ready=0, rspK_valid=0, busy=0, rr=0, all counters, tags and buffers cleared; dp_a/dp_b/dp_op/rsp data=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight and buffered operations; datapath outputs arriving after deassertion for pre-reset issues SHALL be ignored.
REQ-030 First grant SHALL be possible in the first cycle after reset_L deasserts.

Verification
REQ-031 Single op: req0 add a=16'h3C00 b=16'h3C00 at t, datapath model returns 16'h4000 -> dp_valid at t+1, rsp0_valid at t+5 (LAT=3) with 16'h4000, flags 000.
REQ-032 Contention: req0 and req1 valid continuously from reset -> grants alternate 0,1,0,1; each dp issue carries the granted requester's operands.
REQ-033 Backpressure: rsp1_ready=0, req1 streaming -> exactly 2 req1 handshakes, then req1_ready=0 while req0 continues unblocked; raising rsp1_ready for one cycle -> one further req1 grant the next cycle.
REQ-034 Ordering: req0 issues 4 ops with distinct b values, rsp0_ready toggling -> responses in issue order, no loss or duplication.
REQ-035 Mid-flight reset: 2 ops issued, reset_L pulsed low at t+2 -> no rsp_valid after deassertion, busy=0, late dp_result ignored.
REQ-036 Stray datapath output: dp_result=16'h7E00 driven with no tag valid -> no buffer push, rsp outputs unchanged.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency FP16 datapath.
// Results return through per-requester FIFOs; credits stop a FIFO from ever overflowing.
module fpu_arbiter #(
  parameter int LAT       = 3,
  parameter int RSP_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic        dp_valid,
  output logic [15:0] dp_a,
  output logic [15:0] dp_b,
  output logic [1:0]  dp_op,
  input  logic [15:0] dp_result,
  input  logic [2:0]  dp_flags,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_result,
  output logic [2:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_result,
  output logic [2:0]  rsp1_flags,
  output logic        busy
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);
  localparam logic [3:0] DEPTH_L = 4'(RSP_DEPTH);

  // Handshake rule: a request transfers when valid and ready are both 1 in the
  // same cycle; a response pops when rspK_valid and rspK_ready are both 1.
  logic          rr;
  logic [1:0]    reqValid, rspReady, eligible, grant, push, pop, rspValid;
  logic [2:0]    inflight [2];
  logic [2:0]    occ [2];
  logic [PW-1:0] rdPtr [2];
  logic [PW-1:0] wrPtr [2];
  logic [18:0]   mem [2][RSP_DEPTH];
  logic [LAT-1:0] tagValid, tagId;
  logic          dpId;
  logic          issue, issueId;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign reqValid = {req1_valid, req0_valid};
  assign rspReady = {rsp1_ready, rsp0_ready};

  // Credits use registered counts only, so a pop frees a slot one cycle later.
  always_comb begin
    eligible = '0;
    rspValid = '0;
    pop      = '0;
    push     = '0;
    for (int k = 0; k < 2; k++) begin
      eligible[k] = ({1'b0, inflight[k]} + {1'b0, occ[k]}) < DEPTH_L;
      rspValid[k] = (occ[k] != 3'd0);
      pop[k]      = rspValid[k] & rspReady[k];
      push[k]     = tagValid[LAT-1] & (tagId[LAT-1] == 1'(k));
    end
  end

  always_comb begin
    grant = 2'b00;
    if (reset_L) begin
      if ((reqValid & eligible) == 2'b11) grant = rr ? 2'b10 : 2'b01;
      else                                grant = reqValid & eligible;
    end
  end

  assign issue      = |grant;
  assign issueId    = grant[1];
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      rr       <= 1'b0;
      dp_valid <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
      dp_op    <= '0;
      dpId     <= 1'b0;
    end else begin
      dp_valid <= issue;
      if (issue) begin
        rr    <= ~issueId;
        dpId  <= issueId;
        dp_a  <= issueId ? req1_a  : req0_a;
        dp_b  <= issueId ? req1_b  : req0_b;
        dp_op <= issueId ? req1_op : req0_op;
      end
    end
  end

  // Tag enters with dp_valid and leaves exactly when the datapath result is valid.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      tagValid <= '0;
      tagId    <= '0;
    end else begin
      tagValid[0] <= dp_valid;
      tagId[0]    <= dpId;
      for (int i = 1; i < LAT; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagId[i]    <= tagId[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < 2; k++) begin
        inflight[k] <= '0;
        occ[k]      <= '0;
        rdPtr[k]    <= '0;
        wrPtr[k]    <= '0;
        for (int e = 0; e < RSP_DEPTH; e++) mem[k][e] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        case ({grant[k], push[k]})
          2'b10:   inflight[k] <= inflight[k] + 3'd1;
          2'b01:   inflight[k] <= inflight[k] - 3'd1;
          default: inflight[k] <= inflight[k];
        endcase
        case ({push[k], pop[k]})
          2'b10:   occ[k] <= occ[k] + 3'd1;
          2'b01:   occ[k] <= occ[k] - 3'd1;
          default: occ[k] <= occ[k];
        endcase
        if (push[k]) begin
          mem[k][wrPtr[k]] <= {dp_result, dp_flags};
          wrPtr[k]         <= nextPtr(wrPtr[k]);
        end
        if (pop[k]) rdPtr[k] <= nextPtr(rdPtr[k]);
      end
    end
  end

  assign rsp0_valid                = rspValid[0];
  assign rsp1_valid                = rspValid[1];
  assign {rsp0_result, rsp0_flags} = mem[0][rdPtr[0]];
  assign {rsp1_result, rsp1_flags} = mem[1][rdPtr[1]];
  assign busy = (|tagValid) | dp_valid | (|rspValid);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: fixed-latency datapath model, arbitration vector table,
// and hand-written sequences for latency, backpressure, ordering, reset and stray outputs.
module tb_fpu_arbiter;

  localparam int LAT = 3;
  localparam logic [15:0] STRAY_RESULT = 16'h7E00;

  logic        clock, reset_L;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        dp_valid;
  logic [15:0] dp_a, dp_b, dp_result;
  logic [1:0]  dp_op;
  logic [2:0]  dp_flags;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_result, rsp1_result;
  logic [2:0]  rsp0_flags, rsp1_flags;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int pop0Cnt = 0;

  logic [33:0] iss_q[$];
  logic [18:0] exp0_q[$];
  logic [18:0] exp1_q[$];

  fpu_arbiter #(.LAT(LAT), .RSP_DEPTH(2)) dut (
    .clock(clock), .reset_L(reset_L),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
    .dp_result(dp_result), .dp_flags(dp_flags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .busy(busy)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Stand-in datapath: 1.0+1.0 gives 2.0, anything else a fixed scramble.
  function automatic logic [18:0] dp_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    if (a == 16'h3C00 && b == 16'h3C00 && op == 2'b00) return {16'h4000, 3'b000};
    return {a ^ {b[14:0], 1'b0} ^ {14'b0, op}, a[2:0] ^ b[2:0]};
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [18:0]    pd [LAT];
  always @(posedge clock) begin
    pv    <= {pv[LAT-2:0], dp_valid};
    pd[0] <= dp_model(dp_a, dp_b, dp_op);
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign dp_result = pv[LAT-1] ? pd[LAT-1][18:3] : STRAY_RESULT;
  assign dp_flags  = pv[LAT-1] ? pd[LAT-1][2:0]  : 3'b111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Scoreboard: issue order, response order/content, hold stability, ready exclusivity
  logic        hold0 = 1'b0, hold1 = 1'b0;
  logic [18:0] held0, held1;
  always @(negedge clock) begin
    if (!reset_L) begin
      iss_q.delete();
      exp0_q.delete();
      exp1_q.delete();
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      check("ready_exclusive", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (dp_valid) begin
        if (iss_q.size() == 0) failNow("dp_issue_unexpected");
        else check("dp_issue", 32'({dp_a[13:0], dp_b, dp_op}), 32'(iss_q.pop_front() & 34'h0_FFFF_FFFF));
      end
      if (req0_valid && req0_ready) begin
        iss_q.push_back({req0_a, req0_b, req0_op});
        exp0_q.push_back(dp_model(req0_a, req0_b, req0_op));
      end
      if (req1_valid && req1_ready) begin
        iss_q.push_back({req1_a, req1_b, req1_op});
        exp1_q.push_back(dp_model(req1_a, req1_b, req1_op));
      end
      if (hold0) check("rsp0_hold", {12'b0, rsp0_valid, rsp0_result, rsp0_flags}, {12'b0, 1'b1, held0});
      if (hold1) check("rsp1_hold", {12'b0, rsp1_valid, rsp1_result, rsp1_flags}, {12'b0, 1'b1, held1});
      if (rsp0_valid && rsp0_ready) begin
        pop0Cnt++;
        if (exp0_q.size() == 0) failNow("rsp0_unexpected");
        else check("rsp0_data", {13'b0, rsp0_result, rsp0_flags}, {13'b0, exp0_q.pop_front()});
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp1_q.size() == 0) failNow("rsp1_unexpected");
        else check("rsp1_data", {13'b0, rsp1_result, rsp1_flags}, {13'b0, exp1_q.pop_front()});
      end
      hold0 = rsp0_valid && !rsp0_ready;
      held0 = {rsp0_result, rsp0_flags};
      hold1 = rsp1_valid && !rsp1_ready;
      held1 = {rsp1_result, rsp1_flags};
    end
  end

  // Driver tasks
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset_L    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic waitIdle();
    int cnt = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    while ((busy || exp0_q.size() != 0 || exp1_q.size() != 0) && cnt < 200) begin
      nextCycle();
      cnt++;
    end
    check("drain_in_budget", {31'b0, cnt < 200}, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    logic v0, v1;
    logic r0, r1;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int n, cyc, hs0, hs1;
    logic [18:0] want;

    // Arbitration table from a fresh reset, responses always accepted.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0};

    reset_L    = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = 16'h0001; req0_b = 16'h0002; req0_op = 2'b00;
    req1_a = 16'h0003; req1_b = 16'h0004; req1_op = 2'b01;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_dp_valid", {31'b0, dp_valid}, 32'd0);
    check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    check("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_dp_data", {dp_a, dp_b}, 32'd0);
    check("rst_rsp_data", {rsp0_result, rsp1_result}, 32'd0);

    // Table: contention, credit stalls, single-requester grants
    doReset();
    for (int i = 0; i < 12; i++) begin
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      req0_a = 16'h1100 + 16'(i); req0_b = 16'h2200 + 16'(i); req0_op = 2'(i);
      req1_a = 16'h5500 + 16'(i); req1_b = 16'h6600 + 16'(i); req1_op = 2'(i + 1);
      @(negedge clock);
      check($sformatf("tbl%0d_ready", i), {30'b0, req1_ready, req0_ready}, {30'b0, tbl[i].r1, tbl[i].r0});
      nextCycle();
    end
    waitIdle();

    // Single op latency
    doReset();
    req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00; req0_op = 2'b00;
    @(negedge clock);
    check("single_ready", {31'b0, req0_ready}, 32'd1);
    nextCycle();
    req0_valid = 1'b0;
    @(negedge clock);
    check("single_dp_valid", {31'b0, dp_valid}, 32'd1);
    check("single_dp_ops", {dp_a, dp_b}, 32'h3C00_3C00);
    cyc = 1;
    while (!rsp0_valid && cyc < 20) begin
      nextCycle();
      @(negedge clock);
      cyc++;
    end
    check("single_latency", cyc, 32'd5);
    check("single_result", {13'b0, rsp0_result, rsp0_flags}, {13'b0, 16'h4000, 3'b000});
    waitIdle();

    // Backpressure on requester 1
    doReset();
    rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0A0A; req0_b = 16'h0B0B; req0_op = 2'b10;
    req1_valid = 1'b1; req1_a = 16'h1A1A; req1_b = 16'h1B1B; req1_op = 2'b01;
    hs0 = 0;
    hs1 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (req0_ready) hs0++;
      if (req1_ready) hs1++;
      nextCycle();
    end
    check("bp_req1_count", hs1, 32'd2);
    check("bp_req0_count", hs0, 32'd7);
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    @(negedge clock);
    check("bp_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
    check("bp_pop_cycle_ready", {31'b0, req1_ready}, 32'd0);
    nextCycle();
    rsp1_ready = 1'b0;
    @(negedge clock);
    check("bp_regrant", {31'b0, req1_ready}, 32'd1);
    nextCycle();
    @(negedge clock);
    check("bp_full_again", {31'b0, req1_ready}, 32'd0);
    nextCycle();
    waitIdle();

    // Ordering with toggling response ready
    doReset();
    pop0Cnt = 0;
    n = 0;
    cyc = 0;
    rsp0_ready = 1'b0;
    while (!(n == 4 && pop0Cnt == 4) && cyc < 100) begin
      rsp0_ready = ~rsp0_ready;
      req0_valid = (n < 4);
      req0_a = 16'h4400; req0_b = 16'h0100 * 16'(n + 1); req0_op = 2'b01;
      @(negedge clock);
      if (req0_valid && req0_ready) n++;
      nextCycle();
      cyc++;
    end
    check("order_issued", n, 32'd4);
    check("order_popped", pop0Cnt, 32'd4);
    check("order_queue_empty", exp0_q.size(), 32'd0);
    waitIdle();

    // Reset with two ops in flight
    doReset();
    req0_valid = 1'b1; req0_a = 16'h0C01; req0_b = 16'h0D01; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 16'h0C02; req1_b = 16'h0D02; req1_op = 2'b10;
    @(negedge clock);
    check("mid_grant0", {31'b0, req0_ready}, 32'd1);
    nextCycle();
    req0_valid = 1'b0;
    @(negedge clock);
    check("mid_grant1", {31'b0, req1_ready}, 32'd1);
    nextCycle();
    req1_valid = 1'b0;
    reset_L = 1'b0;
    @(negedge clock);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_dp_valid", {31'b0, dp_valid}, 32'd0);
    nextCycle();
    reset_L = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("mid_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      check("mid_no_busy", {31'b0, busy}, 32'd0);
      nextCycle();
    end

    // Stray datapath output while a response is parked
    doReset();
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0123; req0_b = 16'h0456; req0_op = 2'b10;
    want = dp_model(16'h0123, 16'h0456, 2'b10);
    @(negedge clock);
    nextCycle();
    req0_valid = 1'b0;
    cyc = 0;
    @(negedge clock);
    while (!rsp0_valid && cyc < 20) begin
      nextCycle();
      @(negedge clock);
      cyc++;
    end
    check("stray_first_rsp", {31'b0, rsp0_valid}, 32'd1);
    check("stray_first_data", {13'b0, rsp0_result, rsp0_flags}, {13'b0, want});
    for (int c = 0; c < 6; c++) begin
      nextCycle();
      @(negedge clock);
      check("stray_rsp0_kept", {12'b0, rsp0_valid, rsp0_result, rsp0_flags}, {12'b0, 1'b1, want});
      check("stray_rsp1_quiet", {31'b0, rsp1_valid}, 32'd0);
      check("stray_busy", {31'b0, busy}, 32'd1);
    end
    nextCycle();
    rsp0_ready = 1'b1;
    nextCycle();
    rsp0_ready = 1'b0;
    @(negedge clock);
    check("stray_no_push", {31'b0, rsp0_valid}, 32'd0);
    check("stray_idle", {31'b0, busy}, 32'd0);
    nextCycle();
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
